// File: rtl/occupancy_detector.sv
// Motion-sensor conditioning: threshold qualification, N-hit confirmation and
// a post-miss hold timer driving the presence bus for the lighting block.
`ifndef MOTION_SENSOR_DATA_WIDTH
`define MOTION_SENSOR_DATA_WIDTH 8
`endif

module occupancy_detector #(
  parameter int MOTION_THRESHOLD = 8,
  parameter int CONFIRM_COUNT    = 3,
  parameter int HOLD_CYCLES      = 1000,
  parameter int CNT_W            = 16,
  parameter int DATA_W           = `MOTION_SENSOR_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] motion_raw,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] presence,
  output logic [1:0]        occ_state,
  output logic              motion_event
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONFIRM = 2'd1, OCCUPIED = 2'd2, HOLD = 2'd3} state_e;

  localparam logic [DATA_W-1:0] THR       = DATA_W'(MOTION_THRESHOLD);
  localparam logic [3:0]        CONF_N    = 4'(CONFIRM_COUNT);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       confirm_q, confirm_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             presence_q, presence_d;
  logic             event_q, event_d;
  logic             hit, miss;

  assign hit  = sample_valid && (motion_raw >= THR);
  assign miss = sample_valid && !hit;

  always_comb begin
    state_d   = state_q;
    confirm_d = confirm_q;
    hold_d    = hold_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          if (CONF_N == 4'd1) begin
            state_d = OCCUPIED;
          end else begin
            state_d   = CONFIRM;
            confirm_d = 4'd1;
          end
        end
      end
      CONFIRM: begin
        // Gaps in sample_valid leave the count untouched; only a miss aborts.
        if (hit) begin
          if (confirm_q + 4'd1 == CONF_N) begin
            state_d   = OCCUPIED;
            confirm_d = 4'd0;
          end else begin
            confirm_d = confirm_q + 4'd1;
          end
        end else if (miss) begin
          state_d   = IDLE;
          confirm_d = 4'd0;
        end
      end
      OCCUPIED: begin
        if (miss) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (hit)                 state_d = OCCUPIED;
        else if (hold_q == '0)   state_d = IDLE;
        else                     hold_d  = hold_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign presence_d = (state_d == OCCUPIED) || (state_d == HOLD);
  // Only fresh occupancy pulses; a HOLD retrigger is the same occupancy.
  assign event_d    = (state_d == OCCUPIED) && ((state_q == IDLE) || (state_q == CONFIRM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      confirm_q  <= 4'd0;
      hold_q     <= '0;
      presence_q <= 1'b0;
      event_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      confirm_q  <= confirm_d;
      hold_q     <= hold_d;
      presence_q <= presence_d;
      event_q    <= event_d;
    end
  end

  assign presence     = DATA_W'(presence_q);
  assign occ_state    = state_q;
  assign motion_event = event_q;

endmodule

// File: tb/tb_occupancy_detector.sv
// Directed bench for occupancy_detector: THRESHOLD 8, CONFIRM 3, HOLD 20.
`ifndef MOTION_SENSOR_DATA_WIDTH
`define MOTION_SENSOR_DATA_WIDTH 8
`endif

module tb_occupancy_detector;
  localparam int DW = `MOTION_SENSOR_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] motion_raw;
  logic          sample_valid;
  logic [DW-1:0] presence;
  logic [1:0]    occ_state;
  logic          motion_event;

  int nchk = 0;
  int nerr = 0;

  occupancy_detector #(
    .MOTION_THRESHOLD(8), .CONFIRM_COUNT(3), .HOLD_CYCLES(20), .CNT_W(16), .DATA_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .motion_raw(motion_raw), .sample_valid(sample_valid),
    .presence(presence), .occ_state(occ_state), .motion_event(motion_event)
  );

  always #5 clk = ~clk;

  // Apply one sample, clock it in, and leave time 1ns past the edge.
  task automatic step(input int raw, input bit vld);
    motion_raw   = DW'(raw);
    sample_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; motion_raw = '0; sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; motion_raw = DW'(255); sample_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      nchk++; if (presence !== DW'(0)) begin nerr++; $display("FAIL reset_presence cyc%0d got %0d want 0", i, presence); end
      nchk++; if (occ_state !== 2'd0) begin nerr++; $display("FAIL reset_state cyc%0d got %0d want 0", i, occ_state); end
      nchk++; if (motion_event !== 1'b0) begin nerr++; $display("FAIL reset_event cyc%0d got %0d want 0", i, motion_event); end
    end
    reset = 1'b1;
    step(255, 1);
    nchk++; if (occ_state !== 2'd1) begin nerr++; $display("FAIL reset_release_state got %0d want 1", occ_state); end
  endtask

  task automatic test_confirm();
    int raws[3] = '{10, 9, 8};
    logic [1:0] exp_s[3] = '{2'd1, 2'd1, 2'd2};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(raws[i], 1);
      nchk++; if (occ_state !== exp_s[i]) begin nerr++; $display("FAIL confirm_state hit%0d got %0d want %0d", i, occ_state, exp_s[i]); end
      nchk++; if (presence !== DW'(i == 2)) begin nerr++; $display("FAIL confirm_presence hit%0d got %0d want %0d", i, presence, i == 2); end
      nchk++; if (motion_event !== (i == 2)) begin nerr++; $display("FAIL confirm_event hit%0d got %0d want %0d", i, motion_event, i == 2); end
    end
    step(0, 0);
    nchk++; if (motion_event !== 1'b0) begin nerr++; $display("FAIL confirm_event_pulse got %0d want 0", motion_event); end
    nchk++; if (occ_state !== 2'd2 || presence !== DW'(1)) begin nerr++; $display("FAIL confirm_stay got s%0d p%0d want s2 p1", occ_state, presence); end
  endtask

  task automatic test_abort_gaps();
    do_reset();
    step(10, 1); step(10, 1);
    nchk++; if (occ_state !== 2'd1) begin nerr++; $display("FAIL abort_pre got %0d want 1", occ_state); end
    step(7, 1);
    nchk++; if (occ_state !== 2'd0 || presence !== DW'(0)) begin nerr++; $display("FAIL abort got s%0d p%0d want s0 p0", occ_state, presence); end
    step(10, 1);
    for (int i = 0; i < 4; i++) begin
      step(200, 0);
      nchk++; if (occ_state !== 2'd1 || presence !== DW'(0)) begin nerr++; $display("FAIL gap%0d got s%0d p%0d want s1 p0", i, occ_state, presence); end
    end
    step(10, 1);
    nchk++; if (occ_state !== 2'd1) begin nerr++; $display("FAIL gap_hit2 got %0d want 1", occ_state); end
    step(10, 1);
    nchk++; if (occ_state !== 2'd2 || motion_event !== 1'b1) begin nerr++; $display("FAIL gap_hit3 got s%0d e%0d want s2 e1", occ_state, motion_event); end
  endtask

  task automatic test_hold_timing();
    step(0, 1);  // edge E
    nchk++; if (occ_state !== 2'd3 || presence !== DW'(1)) begin nerr++; $display("FAIL hold_enter got s%0d p%0d want s3 p1", occ_state, presence); end
    for (int k = 1; k <= 19; k++) begin
      step(0, 0);
      nchk++; if (occ_state !== 2'd3 || presence !== DW'(1)) begin nerr++; $display("FAIL hold_E+%0d got s%0d p%0d want s3 p1", k, occ_state, presence); end
    end
    step(0, 0);  // E+20
    nchk++; if (occ_state !== 2'd0 || presence !== DW'(0)) begin nerr++; $display("FAIL hold_expire got s%0d p%0d want s0 p0", occ_state, presence); end
  endtask

  task automatic test_retrigger();
    do_reset();
    step(10, 1); step(10, 1); step(10, 1);
    step(0, 1);
    for (int k = 1; k <= 9; k++) begin
      step(0, 0);
      nchk++; if (presence !== DW'(1)) begin nerr++; $display("FAIL retrig_hold_E+%0d got %0d want 1", k, presence); end
    end
    step(12, 1);  // E+10
    nchk++; if (occ_state !== 2'd2 || presence !== DW'(1) || motion_event !== 1'b0) begin nerr++; $display("FAIL retrig got s%0d p%0d e%0d want s2 p1 e0", occ_state, presence, motion_event); end
    step(0, 1);
    for (int k = 1; k <= 19; k++) step(0, 0);
    step(8, 1);  // E+20, hold counter at zero
    nchk++; if (occ_state !== 2'd2 || presence !== DW'(1) || motion_event !== 1'b0) begin nerr++; $display("FAIL retrig_zero got s%0d p%0d e%0d want s2 p1 e0", occ_state, presence, motion_event); end
  endtask

  task automatic test_async_reset();
    step(0, 1);
    for (int k = 1; k <= 4; k++) step(0, 0);
    nchk++; if (occ_state !== 2'd3) begin nerr++; $display("FAIL areset_pre got %0d want 3", occ_state); end
    #3 reset = 1'b0;
    #1;
    nchk++; if (presence !== DW'(0) || occ_state !== 2'd0 || motion_event !== 1'b0) begin nerr++; $display("FAIL areset_now got s%0d p%0d e%0d want all 0", occ_state, presence, motion_event); end
    @(posedge clk); #4 reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      nchk++; if (occ_state !== 2'd0 || presence !== DW'(0)) begin nerr++; $display("FAIL areset_after%0d got s%0d p%0d want s0 p0", i, occ_state, presence); end
    end
  endtask

  initial begin
    reset = 1'b0; motion_raw = '0; sample_valid = 1'b0;
    test_reset();
    test_confirm();
    test_abort_gaps();
    test_hold_timing();
    test_retrigger();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
